fetch_unit: RTL and testbench

Instruction fetch stage that drives the program counter into the instruction cache and returns fetched words to decode. Holds the PC register, issues one read per cycle to the combinational icache read port, and buffers results in a 2-entry queue toward decode. Sits between the icache and decode and takes redirect requests from execute. An all-zero instruction word ends the program: the unit halts fetch on it.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, reads the combinational icache every cycle and queues {pc, instr} toward decode.
// Latency: the word at the PC is captured on the edge it is presented and is visible on out_* right after that edge; a redirect target appears 2 edges after the pulse.
// Backpressure: with out_ready low the 2-entry queue fills in 2 cycles, then the PC (and icache_addr) hold until decode pops.
//
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   icache_addr            - byte address to the icache (always the PC register)
//   icache_instr           - icache read data for icache_addr, same cycle
//   redirect_valid/_pc     - one-cycle PC change request from execute (pc[1:0] forced to 0)
//   out_valid/instr/pc     - head of the queue toward decode (instr/pc read 0 when empty)
//   out_ready              - decode accepts the head this cycle
//   halted                 - fetch stopped on an all-zero word or an out-of-range PC
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // First byte address past the icache; 33 bits so a large depth cannot overflow.
  localparam logic [32:0] FETCH_LIMIT = 33'(4 * ICACHE_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  entry_t      queue_q [2];
  entry_t      queue_d [2];

  logic        pop;
  logic        slot_free;
  logic        fetch;
  logic        in_range;
  logic        end_marker;
  logic        push;
  logic        halt_hit;
  logic [1:0]  count_after_pop;

  // The low address bits of a redirect target are dropped by design.
  wire unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Fetch decisions
  // ---------------------------------------------------------------------------
  assign pop        = (count_q != 2'd0) && out_ready;
  // A full queue still accepts a new word when the head leaves this cycle.
  assign slot_free  = (count_q != 2'd2) || pop;
  assign fetch      = (state_q == RUN) && slot_free && !redirect_valid;
  assign in_range   = {1'b0, pc_q} < FETCH_LIMIT;
  assign end_marker = (icache_instr == 32'h0000_0000);
  assign push       = fetch && in_range && !end_marker;
  // A fetch that does not push is either the end marker or an out-of-range PC.
  assign halt_hit   = fetch && !push;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      queue_q[0] <= '0;
      queue_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      queue_q[0] <= queue_d[0];
      queue_q[1] <= queue_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, PC and queue
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    count_d         = count_q;
    queue_d[0]      = queue_q[0];
    queue_d[1]      = queue_q[1];
    count_after_pop = count_q;

    if (redirect_valid) begin
      // Redirect wins over everything: a same-cycle pop is simply consumed,
      // the rest of the queue is discarded and fetch restarts at the target.
      state_d = RUN;
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
    end else begin
      case (state_q)
        RUN:     if (halt_hit) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase

      // Pop shifts the tail into the head; the push then lands in the first
      // free slot, which also covers push+pop on a full queue (count stays 2).
      if (pop) begin
        queue_d[0]      = queue_q[1];
        count_after_pop = count_q - 2'd1;
      end

      if (push) begin
        queue_d[count_after_pop[0]] = '{pc: pc_q, instr: icache_instr};
        count_d                     = count_after_pop + 2'd1;
        pc_d                        = pc_q + 32'd4;
      end else begin
        count_d = count_after_pop;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign icache_addr = pc_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_instr   = out_valid ? queue_q[0].instr : 32'h0000_0000;
  assign out_pc      = out_valid ? queue_q[0].pc    : 32'h0000_0000;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios followed by a randomized run, checked each cycle against a queue-based reference model.
// Latency: one check pass per clock, sampled 1 time unit after the rising edge.
// Backpressure: out_ready is driven per step (held low, held high, or random).
module tb_fetch_unit;

  localparam int unsigned ICW = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clock;
  logic        reset;
  logic [31:0] icache_addr;
  logic [31:0] icache_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        halted;

  logic [31:0] mem [0:31];
  logic [31:0] prog [5] = '{32'h3e800093, 32'h7d008113, 32'hc1810193,
                            32'h83018213, 32'h3e820293};

  // Reference model state
  ent_t        mq [$];
  logic [31:0] m_pc;
  bit          m_halt;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .ICACHE_WORDS (ICW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_instr   (icache_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .halted         (halted)
  );

  // Combinational icache; out-of-range reads return a nonzero word so a
  // wrongly accepted fetch would push garbage instead of halting quietly.
  assign icache_instr = (icache_addr < 32'd128) ? mem[icache_addr[6:2]] : 32'hDEAD_BEEF;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0000_0000;
    m_halt = 1'b0;
  endtask

  // One clock of the fetch rules, written directly from the behaviour:
  // redirect flushes; otherwise pop the head, then fetch if there is room.
  task automatic model_update(input logic rdy, input logic rv, input logic [31:0] rpc);
    bit          popped;
    bit          room;
    logic [31:0] word;
    popped = (mq.size() > 0) && rdy;
    if (rv) begin
      mq.delete();
      m_pc   = {rpc[31:2], 2'b00};
      m_halt = 1'b0;
      return;
    end
    room = !m_halt && ((mq.size() < 2) || popped);
    if (popped) void'(mq.pop_front());
    if (room) begin
      if (m_pc >= 4 * ICW) begin
        m_halt = 1'b1;
      end else begin
        word = mem[m_pc[6:2]];
        if (word == 32'h0) begin
          m_halt = 1'b1;
        end else begin
          mq.push_back('{pc: m_pc, instr: word});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    e_pc    = 32'h0;
    e_instr = 32'h0;
    if (mq.size() > 0) begin
      e_pc    = mq[0].pc;
      e_instr = mq[0].instr;
    end
    chk("m_out_valid",   {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("m_out_pc",      out_pc,             e_pc);
    chk("m_out_instr",   out_instr,          e_instr);
    chk("m_halted",      {31'b0, halted},    {31'b0, m_halt});
    chk("m_icache_addr", icache_addr,        m_pc);
  endtask

  // Drive inputs, advance one edge, then compare everything to the model.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_update(rdy, rv, rpc);
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    check_model();
  endtask

  // Asynchronous reset taken between edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_valid",   {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc",      out_pc,             32'd0);
    chk("rst_out_instr",   out_instr,          32'd0);
    chk("rst_halted",      {31'b0, halted},    32'd0);
    chk("rst_icache_addr", icache_addr,        32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    reset          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 5; i++) mem[i] = prog[i];

    #2;
    do_reset();

    // Program stream with decode always ready.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("s1_pc",    out_pc,    32'(4 * i));
      chk("s1_instr", out_instr, prog[i]);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("s1_halted",    {31'b0, halted},    32'd1);
    chk("s1_drained",   {31'b0, out_valid}, 32'd0);
    chk("s1_halt_addr", icache_addr,        32'd20);

    // Redirect out of HALT.
    step(1'b1, 1'b1, 32'h4);
    chk("rh_halted", {31'b0, halted},    32'd0);
    chk("rh_valid",  {31'b0, out_valid}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("rh_pc", out_pc, 32'(4 * i));
    end
    step(1'b1, 1'b0, 32'h0);
    chk("rh_halt_again", {31'b0, halted}, 32'd1);

    // Redirect mid-stream with an unaligned target.
    step(1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("rm_pc4", out_pc, 32'h4);
    step(1'b1, 1'b1, 32'h0000_000E);
    chk("rm_bubble", {31'b0, out_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("rm_pc_c",    out_pc,    32'h0000_000C);
    chk("rm_instr_c", out_instr, 32'h83018213);
    step(1'b1, 1'b0, 32'h0);
    chk("rm_pc_10", out_pc, 32'h0000_0010);
    step(1'b1, 1'b0, 32'h0);

    // Out-of-range redirect target.
    step(1'b1, 1'b1, 32'h0000_0080);
    chk("oor_not_yet", {31'b0, halted}, 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("oor_halted", {31'b0, halted},    32'd1);
    chk("oor_valid",  {31'b0, out_valid}, 32'd0);
    chk("oor_addr",   icache_addr,        32'h0000_0080);
    step(1'b1, 1'b0, 32'h0);

    // Backpressure from reset.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    chk("bp_head", out_pc,             32'h0);
    chk("bp_addr", icache_addr,        32'h8);
    chk("bp_vld",  {31'b0, out_valid}, 32'd1);
    for (int i = 1; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("bp_seq", out_pc, 32'(4 * i));
    end
    step(1'b1, 1'b0, 32'h0);
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Reset with two entries queued, then restart.
    step(1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("mr_full_addr", icache_addr, 32'h8);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    chk("mr_restart", out_pc, 32'h0);

    // Randomized program, backpressure, redirects and occasional resets.
    for (int i = 0; i < 32; i++) begin
      r = $urandom;
      if ($urandom_range(0, 15) == 0) r = 32'h0;
      mem[i] = r;
    end
    step(1'b1, 1'b1, 32'h0);
    for (int n = 0; n < 2000; n++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 135));
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, rv, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
